pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and stall controller for the 8-bit four-stage pipeline (IF, ID, EX, WB; data memory accessed in EX).
- Each cycle it decides pipeline-register enables, bubbles and flushes.
- It selects operand forwarding for the ID/EX operands.
- It sequences multi-cycle data-memory accesses with a req/ack handshake and timeout.
- It keeps a saturating stall-cycle counter for the top-level bench.

## Interface
- MEM_TIMEOUT, 15: maximum MEM_WAIT cycles before the access is abandoned (1..255).
- CNT_W, 8: width of stall_cnt.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset); one clock domain.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  3  ID source registers.
- id_use1, id_use2  in  1  ID actually reads rs1 / rs2.
- ex_valid  in  1  EX holds a real instruction.
- ex_rd  in  3  EX destination register.
- ex_regwrite, ex_memread, ex_memwrite  in  1  EX control bits.
- ex_branch_taken  in  1  branch resolved taken in EX.
- wb_valid, wb_regwrite  in  1  WB control bits.
- wb_rd  in  3  WB destination register.
- mem_ack  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  load a bubble into IF/ID.
- idex_bubble  out  1  load a bubble into ID/EX.
- ex_hold  out  1  ID/EX register keeps its contents.
- wb_bubble  out  1  load a bubble into EX/WB.
- fwd_a, fwd_b  out  2  operand source: 00 register file, 01 EX result, 10 WB result.
- mem_req  out  1  data memory request.
- mem_err  out  1  one-cycle pulse on timeout.
- stall_cnt  out  CNT_W  count of cycles with pc_en=0 after reset, saturating.

## Operation
- States: RUN, MEM_WAIT. A wait counter wcnt counts MEM_WAIT cycles.
- Default outputs in RUN: pc_en=1, ifid_en=1, all bubbles, flush and hold 0.
- mem_req = ex_valid & (ex_memread | ex_memwrite) in RUN. It is forced to 1 in MEM_WAIT.
- RUN priority order, highest first:
  1. Memory wait. mem_req=1 and mem_ack=0: go to MEM_WAIT with wcnt=1. Assert pc_en=0, ifid_en=0, ex_hold=1, wb_bubble=1.
  2. Branch. ex_valid & ex_branch_taken: assert ifid_flush=1 and idex_bubble=1. pc_en stays 1 so the PC loads the target.
  3. Load-use. ex_valid & ex_memread & id_valid, and ex_rd matches (id_use1 & rs1) or (id_use2 & rs2): pc_en=0, ifid_en=0, idex_bubble=1 for this cycle only.
- A load with mem_ack=1 in its first EX cycle takes no memory stall.
- MEM_WAIT outputs: pc_en=0, ifid_en=0, ex_hold=1, wb_bubble=1, mem_req=1.
- MEM_WAIT exit on ack: mem_ack=1 releases the hold that same cycle (ex_hold=0, wb_bubble=0) and returns to RUN. Branch and load-use are not evaluated that cycle; they are re-evaluated next cycle.
- MEM_WAIT exit on timeout: mem_ack=0 with wcnt==MEM_TIMEOUT behaves like the ack cycle and also pulses mem_err=1. Otherwise wcnt increments.
- Forwarding: fwd_a=01 if ex_valid & ex_regwrite & !ex_memread & ex_rd==id_rs1. Else 10 if wb_valid & wb_regwrite & wb_rd==id_rs1. Else 00. fwd_b is identical using rs2. EX takes priority over WB. r0 is an ordinary register.
- stall_cnt increments on every cycle with pc_en=0 and saturates at 2^CNT_W-1.

## Timing
- All pipeline-control outputs and mem_req are combinational from state and inputs (Mealy). State, wcnt and stall_cnt are registered.
- While reset=0, regardless of clock: state=RUN, wcnt=0, stall_cnt=0. Outputs are forced to pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1, wb_bubble=1, ex_hold=0, mem_req=0, mem_err=0, fwd_a=fwd_b=00.
- Reset asserted mid-MEM_WAIT drops mem_req immediately. No mem_err is produced.
- Load-use costs exactly 1 cycle. A branch costs 2 squashed instructions, both in the same cycle. An N-cycle memory wait costs N cycles.
- mem_ack is ignored in RUN when mem_req=0.

## Test plan
- Reset release: hold reset=0 for 2 cycles -> pc_en=0, flush=1, stall_cnt=0. First cycle after release -> pc_en=1, fwd=00.
- EX/WB forwarding:
  - ALU write r3 in EX, ID reads rs1=3 -> fwd_a=01.
  - Same r3 also in WB -> fwd_a remains 01.
  - r3 only in WB -> fwd_a=10.
  - No match -> 00.
- Load-use: load r2 in EX with mem_ack=1, ID uses rs2=2 -> exactly one cycle of pc_en=0, idex_bubble=1. Next cycle fwd_b=10. stall_cnt=1.
- Memory wait: mem_ack arrives 3 cycles after mem_req -> ex_hold=1 for cycles 1-2, release on cycle 3, stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, mem_ack never asserted -> mem_err pulses on the 4th MEM_WAIT cycle, then RUN. Apply reset mid-wait on a second run -> mem_req falls with reset, no mem_err.
- Branch vs load-use: taken branch in EX while load-use condition also true -> ifid_flush=1, idex_bubble=1, pc_en=1, no stall.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for the four-stage (IF, ID, EX, WB) 8-bit pipeline.
// Drives the pipeline-register enables, bubbles and flushes, and the operand forwarding selects.
// Sequences multi-cycle data-memory accesses using a req/ack handshake with a timeout.
// Counts stall cycles in a saturating counter.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [2:0]       id_rs1,
    input  logic [2:0]       id_rs2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic             ex_valid,
    input  logic [2:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic             ex_memwrite,
    input  logic             ex_branch_taken,
    input  logic             wb_valid,
    input  logic             wb_regwrite,
    input  logic [2:0]       wb_rd,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             ex_hold,
    output logic             wb_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_req,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {StRun, StMemWait} state_e;

    localparam logic [7:0]       TimeoutVal = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne     = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [7:0]       wcnt_q, wcnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic mem_access;
    logic mem_stall;
    logic branch;
    logic load_use;
    logic timeout;
    logic ex_fwd_ok;
    logic wb_fwd_ok;

    assign mem_access = ex_valid & (ex_memread | ex_memwrite);
    assign mem_stall  = mem_access & ~mem_ack;
    assign branch     = ex_valid & ex_branch_taken;
    assign load_use   = ex_valid & ex_memread & id_valid &
                        ((id_use1 & (ex_rd == id_rs1)) | (id_use2 & (ex_rd == id_rs2)));
    // Only meaningful in StMemWait; wcnt is 0 in StRun.
    assign timeout    = ~mem_ack & (wcnt_q == TimeoutVal);
    // A load result is not available in EX, so it can only be forwarded from WB.
    assign ex_fwd_ok  = ex_valid & ex_regwrite & ~ex_memread;
    assign wb_fwd_ok  = wb_valid & wb_regwrite;

    assign stall_cnt  = stall_q;

    // State, wait counter and stall counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StRun;
            wcnt_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            stall_q <= stall_d;
        end
    end

    // Next-state logic: enter the wait on an unacknowledged access, and leave it on ack or timeout.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            StRun: begin
                if (mem_stall) begin
                    state_d = StMemWait;
                    wcnt_d  = 8'd1;
                end
            end
            StMemWait: begin
                if (mem_ack || timeout) begin
                    state_d = StRun;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StRun;
                wcnt_d  = '0;
            end
        endcase
    end

    // Saturating count of cycles in which the PC is frozen.
    always_comb begin
        stall_d = stall_q;
        if (!pc_en && (stall_q != CntMax)) begin
            stall_d = stall_q + CntOne;
        end
    end

    // Mealy outputs: the hazard priority is memory wait, then branch, then load-use.
    // While reset is asserted, the outputs are forced to the reset values.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        ex_hold     = 1'b0;
        wb_bubble   = 1'b0;
        mem_req     = 1'b0;
        mem_err     = 1'b0;

        if (ex_fwd_ok && (ex_rd == id_rs1)) begin
            fwd_a = 2'b01;
        end else if (wb_fwd_ok && (wb_rd == id_rs1)) begin
            fwd_a = 2'b10;
        end else begin
            fwd_a = 2'b00;
        end

        if (ex_fwd_ok && (ex_rd == id_rs2)) begin
            fwd_b = 2'b01;
        end else if (wb_fwd_ok && (wb_rd == id_rs2)) begin
            fwd_b = 2'b10;
        end else begin
            fwd_b = 2'b00;
        end

        case (state_q)
            StRun: begin
                mem_req = mem_access;
                if (mem_stall) begin
                    pc_en     = 1'b0;
                    ifid_en   = 1'b0;
                    ex_hold   = 1'b1;
                    wb_bubble = 1'b1;
                end else if (branch) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            StMemWait: begin
                mem_req = 1'b1;
                pc_en   = 1'b0;
                ifid_en = 1'b0;
                // The ack or timeout cycle releases EX, and branch and load-use wait one cycle.
                if (mem_ack || timeout) begin
                    mem_err = timeout;
                end else begin
                    ex_hold   = 1'b1;
                    wb_bubble = 1'b1;
                end
            end
            default: begin
                pc_en = 1'b0;
            end
        endcase

        if (!reset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            wb_bubble   = 1'b1;
            ex_hold     = 1'b0;
            mem_req     = 1'b0;
            mem_err     = 1'b0;
            fwd_a       = 2'b00;
            fwd_b       = 2'b00;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: each driven cycle pushes its expected outputs,
// which are popped and compared at the following falling edge.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CntW = 8;

    logic            clk;
    logic            reset;
    logic            id_valid;
    logic [2:0]      id_rs1;
    logic [2:0]      id_rs2;
    logic            id_use1;
    logic            id_use2;
    logic            ex_valid;
    logic [2:0]      ex_rd;
    logic            ex_regwrite;
    logic            ex_memread;
    logic            ex_memwrite;
    logic            ex_branch_taken;
    logic            wb_valid;
    logic            wb_regwrite;
    logic [2:0]      wb_rd;
    logic            mem_ack;
    logic            pc_en;
    logic            ifid_en;
    logic            ifid_flush;
    logic            idex_bubble;
    logic            ex_hold;
    logic            wb_bubble;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic            mem_req;
    logic            mem_err;
    logic [CntW-1:0] stall_cnt;

    typedef struct {
        string       tag;
        logic [11:0] outs;
        logic [7:0]  stall;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] run_cnt  = 8'd0;
    logic [11:0] obs;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT(4),
        .CNT_W      (CntW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use1        (id_use1),
        .id_use2        (id_use2),
        .ex_valid       (ex_valid),
        .ex_rd          (ex_rd),
        .ex_regwrite    (ex_regwrite),
        .ex_memread     (ex_memread),
        .ex_memwrite    (ex_memwrite),
        .ex_branch_taken(ex_branch_taken),
        .wb_valid       (wb_valid),
        .wb_regwrite    (wb_regwrite),
        .wb_rd          (wb_rd),
        .mem_ack        (mem_ack),
        .pc_en          (pc_en),
        .ifid_en        (ifid_en),
        .ifid_flush     (ifid_flush),
        .idex_bubble    (idex_bubble),
        .ex_hold        (ex_hold),
        .wb_bubble      (wb_bubble),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
        .mem_req        (mem_req),
        .mem_err        (mem_err),
        .stall_cnt      (stall_cnt)
    );

    assign obs = {pc_en, ifid_en, ifid_flush, idex_bubble, ex_hold, wb_bubble,
                  mem_req, mem_err, fwd_a, fwd_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Output vector layout: pc_en ifid_en flush bubble hold wb_bubble req err fwd_a fwd_b
    function automatic logic [11:0] ov(input bit pc, input bit ifid, input bit fl, input bit bub,
                                       input bit hold, input bit wbb, input bit req,
                                       input bit err, input logic [1:0] fa,
                                       input logic [1:0] fb);
        return {pc, ifid, fl, bub, hold, wbb, req, err, fa, fb};
    endfunction

    // Push this cycle's expectation. stall_cnt seen this cycle counts the earlier frozen cycles.
    task automatic push(input string tag, input logic [11:0] outs);
        exp_t e;
        e.tag  = tag;
        e.outs = outs;
        if (!reset) begin
            run_cnt = 8'd0;
            e.stall = 8'd0;
        end else begin
            e.stall = run_cnt;
            if (!outs[11] && run_cnt != 8'hff) run_cnt = run_cnt + 8'd1;
        end
        sb.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use1 = 0; id_use2 = 0;
        ex_valid = 0; ex_rd = 0; ex_regwrite = 0; ex_memread = 0; ex_memwrite = 0;
        ex_branch_taken = 0; wb_valid = 0; wb_regwrite = 0; wb_rd = 0; mem_ack = 0;
    endtask

    // Compare the DUT against the oldest pending expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_eq(e.tag, 32'(obs), 32'(e.outs));
            check_eq({e.tag, "/cnt"}, 32'(stall_cnt), 32'(e.stall));
        end
    end

    initial begin
        logic [11:0] rst_v;
        logic [11:0] run_v;
        rst_v = ov(0, 0, 1, 1, 0, 1, 0, 0, 2'b00, 2'b00);
        run_v = ov(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        reset = 1'b0;
        clear_inputs();

        // Reset: a pending access and a WB match must not leak through.
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            ex_valid = 1; ex_memwrite = 1;
            wb_valid = 1; wb_regwrite = 1; wb_rd = 0; id_rs1 = 0;
            push("rst", rst_v);
        end
        next_cycle(); reset = 1'b1; clear_inputs(); push("rel", run_v);

        // Forwarding.
        next_cycle(); clear_inputs();
        ex_valid = 1; ex_regwrite = 1; ex_rd = 3;
        id_valid = 1; id_use1 = 1; id_rs1 = 3; id_rs2 = 5;
        push("fwd_ex", ov(1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00));
        next_cycle(); wb_valid = 1; wb_regwrite = 1; wb_rd = 3; id_rs2 = 3;
        push("fwd_exwb", ov(1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01));
        next_cycle(); ex_rd = 4;
        push("fwd_wb", ov(1, 1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10));
        next_cycle(); ex_rd = 3; ex_memread = 1; mem_ack = 1; id_valid = 0;
        push("fwd_ldex", ov(1, 1, 0, 0, 0, 0, 1, 0, 2'b10, 2'b10));
        next_cycle(); clear_inputs();
        ex_valid = 1; ex_regwrite = 1; ex_rd = 6; wb_valid = 1; wb_regwrite = 1; wb_rd = 7;
        id_valid = 1; id_rs1 = 1; id_rs2 = 2;
        push("fwd_none", run_v);
        next_cycle(); ex_rd = 0; id_rs1 = 0;
        push("fwd_r0", ov(1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00));

        // Load-use: one stall cycle, then the load value comes from WB.
        next_cycle(); clear_inputs();
        ex_valid = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 2; mem_ack = 1;
        id_valid = 1; id_use2 = 1; id_rs2 = 2;
        push("lu_stall", ov(0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00));
        next_cycle(); ex_valid = 0; ex_memread = 0; ex_regwrite = 0; mem_ack = 0;
        wb_valid = 1; wb_regwrite = 1; wb_rd = 2;
        push("lu_fwd", ov(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10));
        next_cycle(); clear_inputs();
        ex_valid = 1; ex_memread = 1; ex_rd = 2; mem_ack = 1; id_valid = 1; id_rs2 = 2;
        push("lu_nouse", ov(1, 1, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00));

        // Memory wait that is acknowledged on the third cycle.
        next_cycle(); clear_inputs(); ex_valid = 1; ex_memread = 1; ex_rd = 5;
        push("mw1", ov(0, 0, 0, 0, 1, 1, 1, 0, 2'b00, 2'b00));
        next_cycle();
        push("mw2", ov(0, 0, 0, 0, 1, 1, 1, 0, 2'b00, 2'b00));
        next_cycle(); mem_ack = 1; id_valid = 1; id_use1 = 1; id_rs1 = 5;
        push("mw3_ack", ov(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00));
        next_cycle(); clear_inputs(); mem_ack = 1;
        push("mw_after", run_v);

        // Timeout: mem_err is asserted on the fourth MEM_WAIT cycle.
        next_cycle(); clear_inputs(); ex_valid = 1; ex_memwrite = 1;
        for (int i = 0; i < 4; i++) begin
            push("to_hold", ov(0, 0, 0, 0, 1, 1, 1, 0, 2'b00, 2'b00));
            next_cycle();
        end
        push("to_err", ov(0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00));
        next_cycle(); clear_inputs();
        push("to_run", run_v);

        // Reset in the cycle that would have timed out.
        next_cycle(); ex_valid = 1; ex_memwrite = 1;
        for (int i = 0; i < 4; i++) begin
            push("rw_hold", ov(0, 0, 0, 0, 1, 1, 1, 0, 2'b00, 2'b00));
            next_cycle();
        end
        reset = 1'b0;
        push("rw_rst", rst_v);
        next_cycle(); reset = 1'b1; clear_inputs();
        push("rw_rel", run_v);

        // Branch cases.
        next_cycle(); ex_valid = 1; ex_branch_taken = 1;
        push("br", ov(1, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        next_cycle(); ex_memread = 1; ex_rd = 1; mem_ack = 1;
        id_valid = 1; id_use1 = 1; id_rs1 = 1;
        push("br_lu", ov(1, 1, 1, 1, 0, 0, 1, 0, 2'b00, 2'b00));
        next_cycle(); clear_inputs(); ex_branch_taken = 1;
        push("br_inval", run_v);
        next_cycle(); ex_valid = 1; ex_memwrite = 1;
        push("br_mw", ov(0, 0, 0, 0, 1, 1, 1, 0, 2'b00, 2'b00));
        next_cycle(); mem_ack = 1;
        push("br_mwack", ov(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00));

        // Saturation of the stall counter under a sustained load-use stall.
        next_cycle(); clear_inputs();
        ex_valid = 1; ex_memread = 1; ex_rd = 2; mem_ack = 1;
        id_valid = 1; id_use2 = 1; id_rs2 = 2;
        for (int i = 0; i < 260; i++) begin
            push("sat", ov(0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00));
            next_cycle();
        end
        clear_inputs();
        push("sat_end", run_v);

        next_cycle();
        @(posedge clk);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
